cross_window_gen: RTL and testbench

- Front end for the 5-tap cross sharpening kernel; drives that kernel's slave-side inputs.
- Accepts a raw AXI4-Stream RGB video stream and converts each pixel to 8-bit luma.
- Buffers two luma lines and one RGB line, then emits, per pixel, the Center/Up/Down/Left/Right luma cross, the original RGB and the AXI4-Stream sideband.
- Image borders use edge replication; output frame size equals input frame size.

---
 rtl/cross_window_gen.sv | 214 +++++++++++++++++++++
 tb/tb_cross_window_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_window_gen.sv
// Cross-window front end: converts RGB to luma, keeps two luma lines and one RGB line,
// and presents the edge-replicated C/U/D/L/R luma cross plus original RGB per pixel.
module cross_window_gen #(
    parameter int PXL_D_WIDTH = 8,
    parameter int IMG_WIDTH   = 1920,
    parameter int IMG_HEIGHT  = 1080
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*PXL_D_WIDTH-1:0]   s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tuser,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [PXL_D_WIDTH-1:0]     din0,
    output logic [PXL_D_WIDTH-1:0]     din1,
    output logic [PXL_D_WIDTH-1:0]     din2,
    output logic [PXL_D_WIDTH-1:0]     din3,
    output logic [PXL_D_WIDTH-1:0]     din4,
    output logic [3*PXL_D_WIDTH-1:0]   m_axis_org_pixels,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic                       frame_err
);
    localparam int PW = PXL_D_WIDTH;
    localparam int YW = PXL_D_WIDTH + 8;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [PW-1:0]   r_left;
    logic            r_frame_err;

    logic [PW-1:0]   r_din_c, r_din_u, r_din_d, r_din_l, r_din_r;
    logic [3*PW-1:0] r_org;
    logic            r_m_tvalid, r_m_tuser, r_m_tlast;

    logic [PW-1:0]   r_lb_prev [IMG_WIDTH];
    logic [PW-1:0]   r_lb_cur  [IMG_WIDTH];
    logic [3*PW-1:0] r_rgb_cur [IMG_WIDTH];

    // Channel slices: index 2 = R, 1 = G, 0 = B.
    logic [PW-1:0]   w_ch [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            assign w_ch[gi] = s_axis_tdata[gi*PW +: PW];
        end
    endgenerate

    logic [YW-1:0]   w_y_sum;
    logic [PW-1:0]   w_y;
    assign w_y_sum = YW'(77)  * YW'(w_ch[2])
                   + YW'(150) * YW'(w_ch[1])
                   + YW'(29)  * YW'(w_ch[0]);
    assign w_y     = PW'(w_y_sum >> 8);

    logic            w_adv, w_ready, w_fire, w_sof;
    logic            w_last_col, w_last_row, w_emit;
    logic            w_wr_cur, w_wr_prev, w_tlast_err;
    logic [CW-1:0]   w_col_p1, w_wr_addr;
    logic [PW-1:0]   w_center, w_up, w_down, w_left, w_right;

    assign w_adv = !r_m_tvalid || m_axis_tready;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_FILL: w_ready = 1'b1;
            ST_RUN:           w_ready = w_adv;
            default:          w_ready = 1'b0;
        endcase
    end

    assign s_axis_tready = w_ready & ~rst;
    assign w_fire        = s_axis_tvalid & s_axis_tready;
    assign w_sof         = w_fire & s_axis_tuser;

    assign w_last_col = (r_col == CW'(IMG_WIDTH - 1));
    assign w_last_row = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_col_p1   = w_last_col ? r_col : r_col + CW'(1);

    // Taps for the pixel at column r_col of the row held in lb_cur.
    assign w_center = r_lb_cur[r_col];
    assign w_right  = r_lb_cur[w_col_p1];
    assign w_left   = (r_col == '0) ? w_center : r_left;
    assign w_up     = (r_state == ST_RUN && r_row == RW'(1)) ? w_center : r_lb_prev[r_col];
    assign w_down   = (r_state == ST_FLUSH) ? w_center : w_y;

    assign w_emit = (r_state == ST_RUN && w_fire && !s_axis_tuser)
                 || (r_state == ST_FLUSH && w_adv);

    // A start-of-frame beat always lands at column 0, whatever column we expected.
    assign w_wr_addr   = w_sof ? '0 : r_col;
    assign w_wr_cur    = w_fire && (r_state != ST_IDLE || s_axis_tuser);
    assign w_wr_prev   = w_fire && (r_state == ST_RUN) && !s_axis_tuser;
    assign w_tlast_err = w_wr_cur && (s_axis_tlast != (w_wr_addr == CW'(IMG_WIDTH - 1)));

    always_ff @(posedge clk) begin
        if (w_wr_cur) begin
            r_lb_cur[w_wr_addr]  <= w_y;
            r_rgb_cur[w_wr_addr] <= s_axis_tdata;
        end
        if (w_wr_prev) begin
            r_lb_prev[w_wr_addr] <= r_lb_cur[w_wr_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_left      <= '0;
            r_frame_err <= 1'b0;
            r_din_c     <= '0;
            r_din_u     <= '0;
            r_din_d     <= '0;
            r_din_l     <= '0;
            r_din_r     <= '0;
            r_org       <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_m_tlast   <= 1'b0;
        end else begin
            if (w_tlast_err || (w_sof && r_state != ST_IDLE)) begin
                r_frame_err <= 1'b1;
            end

            if (w_adv) begin
                r_m_tvalid <= w_emit;
                if (w_emit) begin
                    r_din_c   <= w_center;
                    r_din_u   <= w_up;
                    r_din_d   <= w_down;
                    r_din_l   <= w_left;
                    r_din_r   <= w_right;
                    r_org     <= r_rgb_cur[r_col];
                    r_m_tuser <= (r_state == ST_RUN) && (r_row == RW'(1)) && (r_col == '0);
                    r_m_tlast <= w_last_col;
                    r_left    <= w_center;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sof) begin
                        r_state <= ST_FILL;
                        r_col   <= CW'(1);
                        r_row   <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_sof) begin
                        r_col <= CW'(1);
                    end else if (w_fire) begin
                        if (w_last_col) begin
                            r_state <= ST_RUN;
                            r_col   <= '0;
                            r_row   <= RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (w_sof) begin
                        r_state <= ST_FILL;
                        r_col   <= CW'(1);
                        r_row   <= '0;
                    end else if (w_fire) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) r_state <= ST_FLUSH;
                            else            r_row   <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_adv) begin
                        if (w_last_col) begin
                            r_state <= ST_IDLE;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign din0              = r_din_c;
    assign din1              = r_din_u;
    assign din2              = r_din_d;
    assign din3              = r_din_l;
    assign din4              = r_din_r;
    assign m_axis_org_pixels = r_org;
    assign m_axis_tvalid     = r_m_tvalid;
    assign m_axis_tuser      = r_m_tuser;
    assign m_axis_tlast      = r_m_tlast;
    assign frame_err         = r_frame_err;

endmodule

// File: tb/tb_cross_window_gen.sv
// Bench for cross_window_gen on a 4x3 image: a reference cross model fills an
// expected-output queue per frame; a monitor pops and compares on every output handshake.
module tb_cross_window_gen;
    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
    logic [7:0]  din0, din1, din2, din3, din4;
    logic [23:0] m_axis_org_pixels;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic        m_axis_tready;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    bit pat_mode = 1'b0;
    bit body     = 1'b0;

    logic [23:0] img [H][W];
    logic [65:0] q [$];

    cross_window_gen #(.PXL_D_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3), .din4(din4),
        .m_axis_org_pixels(m_axis_org_pixels), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] luma(input logic [23:0] p);
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'(s >> 8);
    endfunction

    // Reference cross with edge replication: {C,U,D,L,R,RGB,tuser,tlast}.
    function automatic logic [65:0] exp_pix(input int r, input int c);
        logic [7:0] cc, u, d, l, rr;
        cc = luma(img[r][c]);
        u = cc; d = cc; l = cc; rr = cc;
        if (r > 0)     u  = luma(img[r-1][c]);
        if (r < H - 1) d  = luma(img[r+1][c]);
        if (c > 0)     l  = luma(img[r][c-1]);
        if (c < W - 1) rr = luma(img[r][c+1]);
        return {cc, u, d, l, rr, img[r][c], 1'(r == 0 && c == 0), 1'(c == W - 1)};
    endfunction

    // m_axis_tready driver: always 1, or the repeating 1,0,0,1,0,1 pattern.
    initial begin
        automatic logic [5:0] pat = 6'b101001;
        automatic int idx = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pat_mode) begin
                m_axis_tready = pat[idx];
                idx = (idx + 1) % 6;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Output monitor / scoreboard consumer.
    initial begin
        logic [65:0] got, exp;
        forever begin
            @(negedge clk);
            got = {din0, din1, din2, din3, din4, m_axis_org_pixels, m_axis_tuser, m_axis_tlast};
            if (!rst && m_axis_tvalid && m_axis_tready) begin
                $display("out n=%0d data=%h", n_out, got);
                n_out++;
                checks++;
                assert (q.size() != 0) else begin
                    failures++;
                    $error("FAIL out_unexpected got=%h exp=none", got);
                end
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    checks++;
                    assert (got === exp) else begin
                        failures++;
                        $error("FAIL out_pixel n=%0d got=%h exp=%h", n_out - 1, got, exp);
                    end
                end
            end
            if (!rst && body && m_axis_tvalid && !m_axis_tready) begin
                checks++;
                assert (s_axis_tready === 1'b0) else begin
                    failures++;
                    $error("FAIL stall_tready got=%b exp=0", s_axis_tready);
                end
            end
        end
    end

    task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
        int n;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready || n >= 200) break;
            n++;
        end
        checks++;
        assert (s_axis_tready === 1'b1) else begin
            failures++;
            $error("FAIL accept_timeout got=%b exp=1", s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int bad_col);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                q.push_back(exp_pix(r, c));
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                body = (r >= 1);
                send_beat(img[r][c], 1'(r == 0 && c == 0),
                          1'(c == W - 1) ^ 1'(r == 0 && c == bad_col));
            end
        end
        body = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || m_axis_tvalid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain got=%0d exp=0 pending", tag, q.size());
        end
    endtask

    task automatic check_err(input string tag, input logic exp);
        checks++;
        assert (frame_err === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, frame_err, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [67:0] v;
        v = {m_axis_tvalid, din0, din1, din2, din3, din4, m_axis_org_pixels,
             m_axis_tuser, m_axis_tlast, frame_err};
        checks++;
        assert (v === '0) else begin
            failures++;
            $error("FAIL %s got=%h exp=0", tag, v);
        end
    endtask

    task automatic fill_const(input logic [23:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 24'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        checks++;
        assert (s_axis_tready === 1'b0) else begin
            failures++;
            $error("FAIL reset_tready got=%b exp=0", s_axis_tready);
        end
        rst = 1'b0;

        fill_const(24'h808080);
        send_frame(-1);
        wait_drain("gray");
        check_err("gray_frame_err", 1'b0);

        fill_const(24'hFF0000);
        send_frame(-1);
        wait_drain("red");

        fill_const(24'h000000);
        img[1][1] = 24'hFFFFFF;
        send_frame(-1);
        wait_drain("impulse");

        fill_random();
        pat_mode = 1'b1;
        send_frame(-1);
        wait_drain("pattern");
        pat_mode = 1'b0;
        check_err("pattern_frame_err", 1'b0);

        // Partial frame A, interrupted by a new frame B at row 1 col 2.
        fill_random();
        q.push_back(exp_pix(0, 0));
        q.push_back(exp_pix(0, 1));
        for (int c = 0; c < W; c++) send_beat(img[0][c], 1'(c == 0), 1'(c == W - 1));
        for (int c = 0; c < 2; c++) send_beat(img[1][c], 1'b0, 1'b0);
        fill_random();
        send_frame(-1);
        wait_drain("resync");
        check_err("resync_frame_err", 1'b1);

        do_reset();
        fill_random();
        send_frame(1);
        wait_drain("tlast_err");
        check_err("tlast_frame_err", 1'b1);

        // Reset right after the last input beat, while the last row flushes.
        fill_random();
        send_frame(-1);
        rst = 1'b1;
        #1;
        check_zero("flush_reset_outputs");
        checks++;
        assert (q.size() == 5) else begin
            failures++;
            $error("FAIL flush_pending got=%0d exp=5", q.size());
        end
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_err("post_reset_frame_err", 1'b0);

        fill_random();
        send_frame(-1);
        wait_drain("post_reset");
        check_err("post_reset_clean_err", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
